filter_buffer_ctrl: RTL and testbench
=====================================

# filter_buffer_ctrl

Filter-side responder for the PE engine's filter fetch interface. Accepts a streamed filter tile from the load path, writes it across `Tout` banks, raises `fb_req_possible` once the tile is fully resident, and serves PE address requests with a fixed 1-cycle read latency on four parallel output lanes. It sits between the filter load DMA stream and the PE engine in the conv datapath.

## Interface
- `Tin`, `` `Tin ``: filter words per output lane per tiled input channel.
- `Tout`, `` `Tout `` (4): bank count, equal to the number of output lanes.
- `FILTER_DW`, `` `FILTER_DW ``: filter word width.
- `FILTER_BUF_AW`, `` `FILTER_BUFFER_AW ``: per-bank address width; depth is 2^AW.
- `W_SIZE`, `` `W_SIZE ``: width of `q_channel`.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `i_load_start` in 1: start tile load; one-cycle pulse, honoured in IDLE only.
- `q_channel` in W_SIZE: tiled input channel count; sampled on an accepted `i_load_start`.
- `i_layer_done` in 1: release the tile and return to IDLE; honoured in READY only.
- `s_filter_data` in FILTER_DW: load stream data.
- `s_filter_vld` in 1: load stream valid.
- `o_s_filter_rdy` out 1: load stream ready.
- `o_load_done` out 1: one-cycle pulse when the tile is complete.
- `o_fb_req_possible` out 1: tile is resident and may be read.
- `fb_req` in 1: PE read request.
- `fb_addr` in FILTER_BUF_AW: PE read address, common to all banks.
- `o_fb_data0`..`o_fb_data3` out FILTER_DW each: bank 0..3 read data.
- `o_err` out 1: sticky access error; present only with `FB_RD_CHECK_EN`.

## Operation
- States:
  - IDLE → LOAD on `i_load_start && q_channel != 0`. On entry, latch `q_channel` and clear `wr_addr` and `wr_bank`. `i_load_start` with `q_channel == 0` is ignored and the block stays in IDLE.
  - LOAD → READY after the last beat is accepted.
  - READY → IDLE on `i_layer_done`.
  - `i_load_start` in LOAD or READY is ignored. `i_layer_done` outside READY is ignored.
- Tile size: `N_ADDR = q_channel*Tin` addresses, and `N_ADDR*Tout` beats in total. `N_ADDR` is computed at FILTER_BUF_AW+1 bits. If `N_ADDR > 2^AW`, the address wraps modulo 2^AW; this is undefined use.
- Beat placement: beat n is written to bank `n mod Tout` at address `n / Tout`. `wr_bank` counts 0..Tout-1. `wr_addr` increments when `wr_bank` wraps from Tout-1 to 0.
- Last beat: `wr_bank == Tout-1 && wr_addr == N_ADDR-1`.
- `o_s_filter_rdy = (state == LOAD)`, a registered-state decode. A beat is accepted when `vld && rdy`. `vld` low stalls the counters.
- Reads:
  - `fb_req` in any state reads address `fb_addr` from all banks.
  - Output lanes are registered. They update only on a request and hold their last value otherwise.
- Memory is two-port (1W, 1R). A read and a write to the same bank/address in the same cycle returns the old data (read-first).
- Reset (including mid-load): state goes to IDLE, counters clear, all outputs go to 0. Memory contents are not reset.

## Timing
- Reset values:
  - `o_s_filter_rdy` = 0, `o_load_done` = 0, `o_fb_req_possible` = 0.
  - `o_fb_data0..3` = 0, `o_err` = 0.
- `i_load_start` at cycle t: `o_s_filter_rdy` = 1 from t+1.
- Last beat accepted at cycle k: at k+1 the state is READY, `o_load_done` = 1 for that single cycle, `o_fb_req_possible` = 1, and `o_s_filter_rdy` = 0.
- `i_layer_done` at cycle t: `o_fb_req_possible` = 0 from t+1.
- `fb_req`/`fb_addr` at cycle t: `o_fb_dataX` holds `bankX[fb_addr]` at t+1. Read latency is fixed at 1, with no stall path; this matches the PE's FB_DELAY of 1.
- Back-to-back requests return one word per cycle.

## Configuration
- `FB_RD_CHECK_EN` defined:
  - `o_err` is set on `fb_req` while the state is not READY.
  - `o_err` is set on `fb_req` with `fb_addr >= N_ADDR`.
  - `o_err` is set on `s_filter_vld` in IDLE or READY.
  - `o_err` is sticky until reset; read data is unaffected.
- `FB_RD_CHECK_EN` undefined: no `o_err` port and no check logic.

## Structure
- `Tin`, `Tout`, `FILTER_DW`, `FILTER_BUFFER_AW` and `W_SIZE` come from the shared `controller_params.vh`.
- State encodings (IDLE=0, LOAD=1, READY=2) are local to this block.
- Sub-module `filter_bank_ram`: 1W1R, registered read, depth 2^AW. It is instantiated Tout times via generate and is shared with later buffers.

## Test plan
- Tin=4, Tout=4, `q_channel=2`, 32 beats of data=n with `vld` always high:
  - `o_load_done` pulses exactly once, 1 cycle after beat 31.
  - `o_fb_req_possible` rises on the same cycle.
  - bank2[5] = 22.
- Same load with `s_filter_vld` toggling every other cycle: identical memory image, and `o_load_done` occurs 1 cycle after the final accepted beat.
- READY, `fb_req` with addresses 0..7 back to back: `o_fb_data0..3` = {4a, 4a+1, 4a+2, 4a+3} one cycle after each address a, with no gaps.
- `i_load_start` with `q_channel=0`: state stays IDLE and `o_s_filter_rdy` stays 0. `i_load_start` during LOAD has no effect on the counters.
- `rstn` asserted after beat 10:
  - all outputs are 0 immediately.
  - A reload with `q_channel=1` completes after 16 beats.
- With `FB_RD_CHECK_EN`, `fb_req` with `fb_addr=8` while `q_channel=2` and READY: `o_err` = 1 at the next cycle and stays 1 until reset.

Source files
------------

// File: rtl/filter_buffer_ctrl_pkg.sv
// Shared parameters, state encoding and tile-size helper for the filter buffer controller.
package filter_buffer_ctrl_pkg;

    localparam int TIN           = 4;
    localparam int TOUT          = 4;
    localparam int FILTER_DW     = 16;
    localparam int FILTER_BUF_AW = 6;
    localparam int W_SIZE        = 8;
    localparam int BANK_W        = $clog2(TOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } fb_state_t;

    // Addresses per bank for a tile; wraps at AW+1 bits by design.
    function automatic logic [FILTER_BUF_AW:0] calc_n_addr(input logic [W_SIZE-1:0] q);
        logic [W_SIZE+7:0] prod;
        prod = {8'd0, q} * {{W_SIZE{1'b0}}, 8'(TIN)};
        return prod[FILTER_BUF_AW:0];
    endfunction

endpackage

// File: rtl/filter_buffer_ctrl_ram.sv
// One filter bank: single write port, single read port, registered read-first output.
// The read register holds its value when no read is issued.
module filter_bank_ram #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/filter_buffer_ctrl.sv
// Filter buffer controller: loads a streamed tile across TOUT banks and serves PE reads.
// Define FB_RD_CHECK_EN to add the sticky o_err access checker.
module filter_buffer_ctrl
    import filter_buffer_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_load_start,
    input  logic [W_SIZE-1:0]        q_channel,
    input  logic                     i_layer_done,
    input  logic [FILTER_DW-1:0]     s_filter_data,
    input  logic                     s_filter_vld,
    output logic                     o_s_filter_rdy,
    output logic                     o_load_done,
    output logic                     o_fb_req_possible,
    input  logic                     fb_req,
    input  logic [FILTER_BUF_AW-1:0] fb_addr,
    output logic [FILTER_DW-1:0]     o_fb_data0,
    output logic [FILTER_DW-1:0]     o_fb_data1,
    output logic [FILTER_DW-1:0]     o_fb_data2,
    output logic [FILTER_DW-1:0]     o_fb_data3
`ifdef FB_RD_CHECK_EN
    ,
    output logic                     o_err
`endif
);

    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(TOUT - 1);

    fb_state_t                state_reg;
    logic [FILTER_BUF_AW-1:0] wr_addr_reg;
    logic [BANK_W-1:0]        wr_bank_reg;
    logic [FILTER_BUF_AW:0]   n_addr_reg;
    logic                     beat_acc;
    logic                     last_beat;
    logic [FILTER_DW-1:0]     rd_data [TOUT];

    assign beat_acc  = s_filter_vld && o_s_filter_rdy;
    assign last_beat = (wr_bank_reg == BANK_LAST) &&
                       (wr_addr_reg == FILTER_BUF_AW'(n_addr_reg - 1'b1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg         <= ST_IDLE;
            wr_addr_reg       <= '0;
            wr_bank_reg       <= '0;
            n_addr_reg        <= '0;
            o_s_filter_rdy    <= 1'b0;
            o_load_done       <= 1'b0;
            o_fb_req_possible <= 1'b0;
        end else begin
            o_load_done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_load_start && (q_channel != '0)) begin
                        state_reg      <= ST_LOAD;
                        n_addr_reg     <= calc_n_addr(q_channel);
                        wr_addr_reg    <= '0;
                        wr_bank_reg    <= '0;
                        o_s_filter_rdy <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (beat_acc) begin
                        if (last_beat) begin
                            state_reg         <= ST_READY;
                            o_s_filter_rdy    <= 1'b0;
                            o_load_done       <= 1'b1;
                            o_fb_req_possible <= 1'b1;
                        end else if (wr_bank_reg == BANK_LAST) begin
                            wr_bank_reg <= '0;
                            wr_addr_reg <= wr_addr_reg + 1'b1;
                        end else begin
                            wr_bank_reg <= wr_bank_reg + 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    if (i_layer_done) begin
                        state_reg         <= ST_IDLE;
                        o_fb_req_possible <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // The bank read register is the output lane, giving the fixed one-cycle latency.
    generate
        for (genvar gi = 0; gi < TOUT; gi++) begin : g_bank
            filter_bank_ram #(
                .DW(FILTER_DW),
                .AW(FILTER_BUF_AW)
            ) u_bank (
                .clk    (clk),
                .rstn   (rstn),
                .wr_en  (beat_acc && (wr_bank_reg == BANK_W'(gi))),
                .wr_addr(wr_addr_reg),
                .wr_data(s_filter_data),
                .rd_en  (fb_req),
                .rd_addr(fb_addr),
                .rd_data(rd_data[gi])
            );
        end
    endgenerate

    assign o_fb_data0 = rd_data[0];
    assign o_fb_data1 = rd_data[1];
    assign o_fb_data2 = rd_data[2];
    assign o_fb_data3 = rd_data[3];

`ifdef FB_RD_CHECK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_err <= 1'b0;
        end else if ((fb_req && (state_reg != ST_READY)) ||
                     (fb_req && ({1'b0, fb_addr} >= n_addr_reg)) ||
                     (s_filter_vld && (state_reg != ST_LOAD))) begin
            o_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_filter_buffer_ctrl.sv
// Scoreboard bench for filter_buffer_ctrl: directed loads, reads, reset and (optionally) error checks.
module tb_filter_buffer_ctrl;
    import filter_buffer_ctrl_pkg::*;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic                     i_load_start = 1'b0;
    logic [W_SIZE-1:0]        q_channel = '0;
    logic                     i_layer_done = 1'b0;
    logic [FILTER_DW-1:0]     s_filter_data = '0;
    logic                     s_filter_vld = 1'b0;
    logic                     o_s_filter_rdy;
    logic                     o_load_done;
    logic                     o_fb_req_possible;
    logic                     fb_req = 1'b0;
    logic [FILTER_BUF_AW-1:0] fb_addr = '0;
    logic [FILTER_DW-1:0]     o_fb_data0, o_fb_data1, o_fb_data2, o_fb_data3;
`ifdef FB_RD_CHECK_EN
    logic                     o_err;
`endif

    filter_buffer_ctrl dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_load_start     (i_load_start),
        .q_channel        (q_channel),
        .i_layer_done     (i_layer_done),
        .s_filter_data    (s_filter_data),
        .s_filter_vld     (s_filter_vld),
        .o_s_filter_rdy   (o_s_filter_rdy),
        .o_load_done      (o_load_done),
        .o_fb_req_possible(o_fb_req_possible),
        .fb_req           (fb_req),
        .fb_addr          (fb_addr),
        .o_fb_data0       (o_fb_data0),
        .o_fb_data1       (o_fb_data1),
        .o_fb_data2       (o_fb_data2),
        .o_fb_data3       (o_fb_data3)
`ifdef FB_RD_CHECK_EN
        ,
        .o_err            (o_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                      chk;
        logic [3:0][FILTER_DW-1:0] d;
    } exp_t;

    exp_t                      exp_q[$];
    logic [FILTER_DW-1:0]      img [TOUT][2**FILTER_BUF_AW];
    int                        n_checks = 0;
    int                        n_errs = 0;
    logic                      req_seen;
    logic                      hold_valid;
    logic [3:0][FILTER_DW-1:0] last_exp;
    logic [3:0][FILTER_DW-1:0] act;

    assign act = {o_fb_data3, o_fb_data2, o_fb_data1, o_fb_data0};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a request sampled at an edge must be answered on the lanes by the next negedge.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) req_seen <= 1'b0;
        else       req_seen <= fb_req;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            last_exp   = '0;
            hold_valid = 1'b1;
        end else if (req_seen) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL rd_unexpected: got %0h expected no read", act);
            end else begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    chk("rd_data", 64'(act), 64'(e.d));
                    last_exp   = e.d;
                    hold_valid = 1'b1;
                end else begin
                    hold_valid = 1'b0;
                end
            end
        end else if (hold_valid) begin
            n_checks++;
            if (act !== last_exp) begin
                n_errs++;
                $display("FAIL rd_hold: got %0h expected %0h", act, last_exp);
            end
        end
    end

    task automatic load_tile(input logic [W_SIZE-1:0] q, input int base, input bit toggle,
                             input int abort_at);
        int nb;
        int sent;
        int guard;
        bit acc;
        nb = int'(q) * TIN * TOUT;
        sent = 0;
        guard = 0;
        i_load_start = 1'b1;
        q_channel = q;
        step();
        i_load_start = 1'b0;
        chk("rdy_after_start", 64'(o_s_filter_rdy), 64'd1);
        while (sent < nb && guard < 1000) begin
            s_filter_vld = toggle ? ((guard % 2) == 0) : 1'b1;
            s_filter_data = FILTER_DW'(base + sent);
            i_load_start = toggle && (sent == 5);
            q_channel = toggle && (sent == 5) ? 8'd3 : q;
            acc = s_filter_vld && o_s_filter_rdy;
            if (acc) img[sent % TOUT][sent / TOUT] = s_filter_data;
            step();
            guard++;
            i_load_start = 1'b0;
            if (acc) sent++;
            if (abort_at > 0 && sent == abort_at) begin
                s_filter_vld = 1'b0;
                return;
            end
            if (sent < nb && o_load_done !== 1'b0) chk("no_early_done", 64'(o_load_done), 64'd0);
        end
        s_filter_vld = 1'b0;
        if (guard >= 1000) begin
            n_checks++;
            n_errs++;
            $display("FAIL load_timeout: got %0d beats expected %0d", sent, nb);
        end
        chk("load_done_pulse", 64'(o_load_done), 64'd1);
        chk("req_possible_up", 64'(o_fb_req_possible), 64'd1);
        chk("rdy_low_ready", 64'(o_s_filter_rdy), 64'd0);
        step();
        chk("load_done_single", 64'(o_load_done), 64'd0);
        chk("req_possible_held", 64'(o_fb_req_possible), 64'd1);
    endtask

    task automatic read_seq(input int first, input int count);
        exp_t e;
        for (int a = first; a < first + count; a++) begin
            fb_req = 1'b1;
            fb_addr = FILTER_BUF_AW'(a);
            e.chk = 1'b1;
            for (int b = 0; b < TOUT; b++) e.d[b] = img[b][a];
            exp_q.push_back(e);
            step();
        end
        fb_req = 1'b0;
        step();
        step();
    endtask

    initial begin
        for (int b = 0; b < TOUT; b++)
            for (int a = 0; a < 2**FILTER_BUF_AW; a++) img[b][a] = '0;
        #12;
        chk("rst_rdy", 64'(o_s_filter_rdy), 64'd0);
        chk("rst_done", 64'(o_load_done), 64'd0);
        chk("rst_possible", 64'(o_fb_req_possible), 64'd0);
        chk("rst_data", 64'(act), 64'd0);
`ifdef FB_RD_CHECK_EN
        chk("rst_err", 64'(o_err), 64'd0);
`endif
        rstn = 1'b1;
        step();

        // Full tile, valid always high: data = beat index.
        load_tile(8'd2, 0, 1'b0, 0);
        chk("bank2_addr5_model", 64'(img[2][5]), 64'd22);
        read_seq(0, 8);

        i_layer_done = 1'b1;
        step();
        i_layer_done = 1'b0;
        chk("possible_after_layer_done", 64'(o_fb_req_possible), 64'd0);

        // Zero channel count must not start a load.
        i_load_start = 1'b1;
        q_channel = 8'd0;
        step();
        i_load_start = 1'b0;
        chk("q0_rdy", 64'(o_s_filter_rdy), 64'd0);
        step();
        chk("q0_rdy_later", 64'(o_s_filter_rdy), 64'd0);

        // Stalled stream plus an ignored mid-load start.
        load_tile(8'd2, 50, 1'b1, 0);
        read_seq(0, 8);

`ifdef FB_RD_CHECK_EN
        begin
            exp_t e;
            chk("err_clear_ready", 64'(o_err), 64'd0);
            e = '0;
            fb_req = 1'b1;
            fb_addr = 6'd8;
            exp_q.push_back(e);
            step();
            fb_req = 1'b0;
            chk("err_out_of_range", 64'(o_err), 64'd1);
            step();
            step();
            chk("err_sticky", 64'(o_err), 64'd1);
        end
`endif

        i_layer_done = 1'b1;
        step();
        i_layer_done = 1'b0;

        // Reset in the middle of a load.
        load_tile(8'd2, 200, 1'b0, 10);
        rstn = 1'b0;
        #1;
        chk("midrst_rdy", 64'(o_s_filter_rdy), 64'd0);
        chk("midrst_done", 64'(o_load_done), 64'd0);
        chk("midrst_possible", 64'(o_fb_req_possible), 64'd0);
        chk("midrst_data", 64'(act), 64'd0);
`ifdef FB_RD_CHECK_EN
        chk("midrst_err", 64'(o_err), 64'd0);
`endif
        @(negedge clk);
        #1;
        rstn = 1'b1;
        step();
        chk("post_rst_rdy", 64'(o_s_filter_rdy), 64'd0);

        load_tile(8'd1, 100, 1'b0, 0);
        read_seq(0, 8);

        step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
